spi_dac_tx: RTL and testbench
=============================

Name: spi_dac_tx

Overview:
- SPI write master driving an external dual-channel 12-bit serial DAC (MCP4922-class, SPI mode 0).
- Output-side counterpart of the ADC SPI reader. It is an alternative to the on-chip dsDAC outputs for two oscBank voices.
- On each sample strobe it latches two unsigned samples and sends frame A, then frame B. It optionally finishes with an LDAC pulse so both channels update together.

Parameters:
- DAC_WIDTH, 12, input sample width; legal range 8..12; left-justified into the 12-bit DAC field, LSBs zero-filled.
- CLK_DIV, 1, SCK half-period in clk0 cycles; minimum 1, giving SCK = 16 MHz at clk0 = 32 MHz.
- CFG_BUF, 0, BUF bit sent in every frame.
- CFG_GA_N, 1, GA_n bit (1 = 1x gain).
- CFG_SHDN_N, 1, SHDN_n bit (1 = active).

Ports:
- clk0 input 1: system clock, 32 MHz.
- reset input 1: reset, asynchronous, active-high.
- tick input 1: one-cycle sample strobe.
- ch_a input DAC_WIDTH: unsigned sample for DAC channel A.
- ch_b input DAC_WIDTH: unsigned sample for DAC channel B.
- sck output 1: SPI clock; idles low.
- cs_n output 1: DAC chip select, active low.
- sdi output 1: serial data to DAC, MSB first.
- ldac_n output 1: latch strobe, active low.
- busy output 1: high while a transfer is in progress.
- overrun output 1: sticky; set when a tick is dropped.

Behaviour:
- Reset values: sck=0, cs_n=1, sdi=0, ldac_n=1 (0 when LDAC feature is absent), busy=0, overrun=0, state=IDLE. All outputs are registered, so there are no glitches on pins.
- Frame format, 16 bits, MSB first: {A/B_n select (1=A? no: bit15 = 0 for A, 1 for B), CFG_BUF, CFG_GA_N, CFG_SHDN_N, data[11:0]}.
- Let H = CLK_DIV.
- States:
  - IDLE: waiting for tick.
  - SETUP:
    - cs_n=0, sck=0, sdi=bit15.
    - Lasts H cycles.
  - SHIFT: for each bit in turn:
    - sck=1 for H cycles (DAC samples on the rising edge).
    - Then sck=0 for H cycles, with the next bit driven at the start of the low phase.
    - The low phase after bit0 is the hold time: sdi keeps bit0, cs_n stays 0.
  - GAP:
    - cs_n=1, sck=0.
    - Lasts H cycles.
  - LDAC (feature only):
    - ldac_n=0 for 2H cycles.
    - Then IDLE.
- Transitions:
  - IDLE + tick: capture ch_a and ch_b into holding registers, then go to SETUP for channel A.
  - GAP after channel A: go to SETUP for channel B.
  - GAP after channel B: go to LDAC, or straight to IDLE when the feature is absent.
- Latency: the first cs_n falling edge occurs 1 cycle after tick. Each frame takes 34H cycles; a full transfer takes 68H cycles, or 70H with LDAC.
- Sample capture: ch_a and ch_b are sampled only on the accepted tick. Input changes during a transfer have no effect on it.
- busy:
  - Goes high the cycle after tick is accepted.
  - Goes low on the cycle the FSM re-enters IDLE.
  - A tick is accepted only while the FSM is in IDLE.
- Dropped ticks:
  - A tick while state is not IDLE sets overrun and is otherwise ignored.
  - This includes a tick in the final cycle of GAP or LDAC.
  - overrun clears only on reset.
- Reset mid-transfer: cs_n rises and sck falls immediately (asynchronously). The partial frame is abandoned and no LDAC pulse is issued.
- Divider: a counter counts 0..H-1 and advances the phase on terminal count. With H=1 the counter is a constant, and sck toggles every cycle in SHIFT.

Optional Feature:
- Macro: SPI_DAC_TX_LDAC_EN.
- Defined: the LDAC state exists. ldac_n pulses low for 2H cycles after channel B's GAP, so both channels update simultaneously. The transfer is 70H cycles.
- Undefined: ldac_n is driven constant 0 from reset, so the DAC updates each channel on cs_n rising. There is no LDAC state, and the transfer is 68H cycles.

Decomposition:
- Shared package/include spi_dac_pkg:
  - state encodings: IDLE, SETUP, SHIFT, GAP, LDAC.
  - FRAME_BITS=16.
  - DAC_FIELD=12.
  - Config bit positions 15..12.
- One natural sub-module, spi_shift_out. It holds the 16-bit serializer, bit counter and half-period divider, and does start/done handshaking with the channel FSM in spi_dac_tx.

Test Plan:
1. Reset release, then tick with ch_a=12'hABC, ch_b=12'h123, H=1.
   - Frame A on sdi: 16'h3ABC.
   - Frame B on sdi: 16'hB123.
   - 16 sck rising edges per frame.
   - cs_n high for exactly 1 cycle between frames.
   - Feature defined: ldac_n low 2 cycles at cycles 69-70.
2. CLK_DIV=3:
   - sck high and low each last 3 cycles.
   - Frame length is 102 cycles.
   - sdi is stable for ≥3 cycles around every sck rising edge.
3. Tick during a transfer (cycle 20), and separately in the last LDAC cycle:
   - overrun goes 1 and stays 1.
   - The transfer completes unchanged.
   - No second transfer starts.
4. Change ch_a and ch_b every cycle during a transfer: the transmitted data equals the values captured at the tick.
5. Assert reset at cycle 10 of frame A:
   - cs_n=1, sck=0, busy=0 in the same cycle.
   - No LDAC pulse.
   - The next tick after release sends a clean frame A.
6. DAC_WIDTH=8, ch_a=8'hFF: frame A data field is 12'hFF0. With the macro undefined, ldac_n=0 throughout.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// Shared definitions for the MCP4922-class SPI DAC writer: FSM states,
// frame geometry, control-bit positions and the frame builder.
package spi_dac_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, LDAC} state_t;

  localparam int FRAME_BITS = 16;
  localparam int DAC_FIELD  = 12;

  localparam int BIT_AB   = 15;
  localparam int BIT_BUF  = 14;
  localparam int BIT_GA   = 13;
  localparam int BIT_SHDN = 12;

  // Bit 15 selects the channel: 0 = A, 1 = B.
  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic                 is_b,
    input logic                 buf_bit,
    input logic                 ga_n,
    input logic                 shdn_n,
    input logic [DAC_FIELD-1:0] field
  );
    logic [FRAME_BITS-1:0] f;
    f                  = '0;
    f[BIT_AB]          = is_b;
    f[BIT_BUF]         = buf_bit;
    f[BIT_GA]          = ga_n;
    f[BIT_SHDN]        = shdn_n;
    f[DAC_FIELD-1:0]   = field;
    return f;
  endfunction

endpackage

// File: rtl/spi_dac_tx_if.sv
// Sample-strobe and SPI pin bundle of spi_dac_tx; master is the SPI master
// (the DAC writer), slave is the sample source / DAC side.
interface spi_dac_tx_if #(
  parameter int DAC_WIDTH = 12
);
  logic                 tick;
  logic [DAC_WIDTH-1:0] ch_a;
  logic [DAC_WIDTH-1:0] ch_b;
  logic                 sck;
  logic                 cs_n;
  logic                 sdi;
  logic                 ldac_n;
  logic                 busy;
  logic                 overrun;

  modport master (
    input  tick, ch_a, ch_b,
    output sck, cs_n, sdi, ldac_n, busy, overrun
  );

  modport slave (
    output tick, ch_a, ch_b,
    input  sck, cs_n, sdi, ldac_n, busy, overrun
  );
endinterface

// File: rtl/spi_shift_out.sv
// 16-bit mode-0 serializer with half-period divider and bit counter; loads on
// 'load', clocks bits out while 'shift' is high, flags the end of the hold phase.
module spi_shift_out
  import spi_dac_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  clk0,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  load,
  input  logic                  setup,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sck,
  output logic                  sdi,
  output logic                  tc,
  output logic                  done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]      div_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-2:0] shreg;

  assign tc   = (div_cnt == DIV_LAST);
  assign done = shift && tc && !sck && (bit_cnt == LAST_BIT);

  // Every phase boundary lands on tc, so restarting at load keeps all
  // phase lengths exact multiples of CLK_DIV.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset)                     div_cnt <= '0;
    else if (load || !run || tc)   div_cnt <= '0;
    else                           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      sck     <= 1'b0;
      sdi     <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sck     <= 1'b0;
      sdi     <= frame[FRAME_BITS-1];
      shreg   <= frame[FRAME_BITS-2:0];
      bit_cnt <= '0;
    end else if (setup && tc) begin
      sck <= 1'b1;
    end else if (shift && tc) begin
      if (sck) begin
        sck <= 1'b0;
        // Bit 0 is held through its low phase as DAC hold time.
        if (bit_cnt != LAST_BIT) begin
          sdi   <= shreg[FRAME_BITS-2];
          shreg <= shreg << 1;
        end
      end else if (bit_cnt != LAST_BIT) begin
        sck     <= 1'b1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_dac_tx.sv
// Dual-channel SPI DAC writer: per tick sends frame A then frame B.
// Define SPI_DAC_TX_LDAC_EN for a trailing 2*CLK_DIV ldac_n pulse; otherwise ldac_n is tied low.
module spi_dac_tx
  import spi_dac_pkg::*;
#(
  parameter int   DAC_WIDTH  = 12,
  parameter int   CLK_DIV    = 1,
  parameter logic CFG_BUF    = 1'b0,
  parameter logic CFG_GA_N   = 1'b1,
  parameter logic CFG_SHDN_N = 1'b1
) (
  input logic          clk0,
  input logic          reset,
  spi_dac_tx_if.master bus
);

  state_t                state, next_state;
  logic                  ch_sel;
  logic [DAC_WIDTH-1:0]  hold_b;
  logic                  accept, load, tc, done;
  logic                  cs_n_d, busy_d;
  logic [FRAME_BITS-1:0] frame;
`ifdef SPI_DAC_TX_LDAC_EN
  logic                  ldac_half;
  logic                  ldac_n_d;
`endif

  function automatic logic [DAC_FIELD-1:0] left_just(input logic [DAC_WIDTH-1:0] x);
    return DAC_FIELD'(x) << (DAC_FIELD - DAC_WIDTH);
  endfunction

  spi_shift_out #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk0  (clk0),
    .reset (reset),
    .run   (state != IDLE),
    .load  (load),
    .setup (state == SETUP),
    .shift (state == SHIFT),
    .frame (frame),
    .sck   (bus.sck),
    .sdi   (bus.sdi),
    .tc    (tc),
    .done  (done)
  );

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ch_sel      <= 1'b0;
      hold_b      <= '0;
      bus.cs_n    <= 1'b1;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
`ifdef SPI_DAC_TX_LDAC_EN
      ldac_half   <= 1'b0;
      bus.ldac_n  <= 1'b1;
`endif
    end else begin
      state    <= next_state;
      bus.cs_n <= cs_n_d;
      bus.busy <= busy_d;
      if (bus.tick && (state != IDLE)) bus.overrun <= 1'b1;
      // Channel A is loaded straight from the port; only B needs holding.
      if (accept) begin
        hold_b <= bus.ch_b;
        ch_sel <= 1'b0;
      end else if ((state == GAP) && tc) begin
        ch_sel <= 1'b1;
      end
`ifdef SPI_DAC_TX_LDAC_EN
      ldac_half  <= (state == LDAC) && (ldac_half ^ tc);
      bus.ldac_n <= ldac_n_d;
`endif
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.tick) next_state = SETUP;
      SETUP: if (tc)       next_state = SHIFT;
      SHIFT: if (done)     next_state = GAP;
      GAP: if (tc) begin
        if (!ch_sel) next_state = SETUP;
        else
`ifdef SPI_DAC_TX_LDAC_EN
          next_state = LDAC;
`else
          next_state = IDLE;
`endif
      end
`ifdef SPI_DAC_TX_LDAC_EN
      LDAC:  if (tc && ldac_half) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && bus.tick;
    load   = accept || ((state == GAP) && tc && !ch_sel);
    frame  = accept ? make_frame(1'b0, CFG_BUF, CFG_GA_N, CFG_SHDN_N, left_just(bus.ch_a))
                    : make_frame(1'b1, CFG_BUF, CFG_GA_N, CFG_SHDN_N, left_just(hold_b));
    cs_n_d = !((next_state == SETUP) || (next_state == SHIFT));
    busy_d = (next_state != IDLE);
`ifdef SPI_DAC_TX_LDAC_EN
    ldac_n_d = (next_state != LDAC);
`endif
  end

`ifndef SPI_DAC_TX_LDAC_EN
  assign bus.ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_tx.sv
// Directed bench for spi_dac_tx: vector table over three parameterisations
// plus overrun, mid-frame reset and SPI_DAC_TX_LDAC_EN-dependent ldac_n checks.
module tb_spi_dac_tx;

  logic        clk0 = 1'b0;
  logic        reset;
  logic        tick;
  logic [11:0] da, db;
  int          sel;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk0 = ~clk0;

  spi_dac_tx_if #(.DAC_WIDTH(12)) bus0 ();
  spi_dac_tx_if #(.DAC_WIDTH(12)) bus1 ();
  spi_dac_tx_if #(.DAC_WIDTH(8))  bus2 ();

  assign bus0.tick = tick && (sel == 0);
  assign bus1.tick = tick && (sel == 1);
  assign bus2.tick = tick && (sel == 2);
  assign bus0.ch_a = da;
  assign bus0.ch_b = db;
  assign bus1.ch_a = da;
  assign bus1.ch_b = db;
  assign bus2.ch_a = da[7:0];
  assign bus2.ch_b = db[7:0];

  spi_dac_tx #(.DAC_WIDTH(12), .CLK_DIV(1)) u0 (.clk0(clk0), .reset(reset), .bus(bus0));
  spi_dac_tx #(.DAC_WIDTH(12), .CLK_DIV(3)) u1 (.clk0(clk0), .reset(reset), .bus(bus1));
  spi_dac_tx #(.DAC_WIDTH(8),  .CLK_DIV(1)) u2 (.clk0(clk0), .reset(reset), .bus(bus2));

  logic m_sck, m_sdi, m_cs_n, m_ldac_n, m_busy, m_overrun;
  always_comb begin
    m_sck = bus0.sck; m_sdi = bus0.sdi; m_cs_n = bus0.cs_n;
    m_ldac_n = bus0.ldac_n; m_busy = bus0.busy; m_overrun = bus0.overrun;
    case (sel)
      1: begin
        m_sck = bus1.sck; m_sdi = bus1.sdi; m_cs_n = bus1.cs_n;
        m_ldac_n = bus1.ldac_n; m_busy = bus1.busy; m_overrun = bus1.overrun;
      end
      2: begin
        m_sck = bus2.sck; m_sdi = bus2.sdi; m_cs_n = bus2.cs_n;
        m_ldac_n = bus2.ldac_n; m_busy = bus2.busy; m_overrun = bus2.overrun;
      end
      default: ;
    endcase
  end

  typedef struct {
    int          sel;
    int          h;
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] fa;
    logic [15:0] fb;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int xfer_len(input int h);
`ifdef SPI_DAC_TX_LDAC_EN
    return 70 * h;
`else
    return 68 * h;
`endif
  endfunction

  // One full transfer on the selected DUT; inputs are scrambled every cycle
  // after the tick, and an extra tick can be injected at cycle tick_at.
  task automatic run_xfer(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input int h, input int tick_at,
                          input logic [15:0] fa, input logic [15:0] fb);
    logic [15:0] fr[2];
    logic [15:0] cur = '0;
    int rises[2], csfall[2];
    int nfr = 0, nr = 0, gap = 0, busy_len = -1;
    int hi_run = 0, hi_min = 999, hi_max = 0, per_min = 999, per_max = 0;
    int last_rise = -1, last_chg = 0, viol = 0;
    int ldac_low = 0, ldac_high = 0, ldac_first = -1;
    logic p_sck, p_sdi, p_cs;
    fr[0] = '0; fr[1] = '0; rises[0] = 0; rises[1] = 0; csfall[0] = 0; csfall[1] = 0;

    @(negedge clk0);
    da = a; db = b; tick = 1'b1;
    p_sck = m_sck; p_sdi = m_sdi; p_cs = m_cs_n;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk0);
      tick = (cyc == tick_at);
      da = 12'($urandom); db = 12'($urandom);
      if (cyc == 1) check({tag, "/first_cycle_cs_busy"}, int'({m_cs_n, m_busy}), 1);
      if (!m_ldac_n) begin
        ldac_low++;
        if (ldac_first < 0) ldac_first = cyc;
      end else ldac_high++;
      if (!m_busy) begin
        busy_len = cyc - 1;
        break;
      end
      if (p_cs && !m_cs_n) begin
        if (nfr < 2) csfall[nfr] = cyc;
        cur = '0; nr = 0; last_rise = -1;
      end
      if (m_sdi != p_sdi) begin
        last_chg = cyc;
        if (m_sck && p_sck) viol++;
      end
      if (!p_sck && m_sck) begin
        cur = {cur[14:0], m_sdi};
        nr++;
        if (cyc - last_chg < h) viol++;
        if (last_rise > 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        hi_run = 0;
      end
      if (m_sck) hi_run++;
      if (p_sck && !m_sck) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
      end
      if (!p_cs && m_cs_n) begin
        if (nfr < 2) begin
          fr[nfr] = cur;
          rises[nfr] = nr;
        end
        nfr++;
      end
      if (m_cs_n && (nfr == 1)) gap++;
      p_sck = m_sck; p_sdi = m_sdi; p_cs = m_cs_n;
    end
    tick = 1'b0;

    check({tag, "/busy_len"},    busy_len, xfer_len(h));
    check({tag, "/frames"},      nfr, 2);
    check({tag, "/frame_a"},     int'(fr[0]), int'(fa));
    check({tag, "/frame_b"},     int'(fr[1]), int'(fb));
    check({tag, "/rises_a"},     rises[0], 16);
    check({tag, "/rises_b"},     rises[1], 16);
    check({tag, "/gap"},         gap, h);
    check({tag, "/frame_len"},   csfall[1] - csfall[0], 34 * h);
    check({tag, "/sck_hi_min"},  hi_min, h);
    check({tag, "/sck_hi_max"},  hi_max, h);
    check({tag, "/sck_per_min"}, per_min, 2 * h);
    check({tag, "/sck_per_max"}, per_max, 2 * h);
    check({tag, "/sdi_stable"},  viol, 0);
`ifdef SPI_DAC_TX_LDAC_EN
    check({tag, "/ldac_low"},    ldac_low, 2 * h);
    check({tag, "/ldac_first"},  ldac_first, 68 * h + 1);
`else
    check({tag, "/ldac_high"},   ldac_high, 0);
`endif
    check({tag, "/overrun"},     int'(m_overrun), (tick_at > 0) ? 1 : 0);
  endtask

  task automatic idle_check(input string tag);
    int busy_hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk0);
      if (m_busy) busy_hi++;
    end
    check({tag, "/no_second_xfer"}, busy_hi, 0);
    check({tag, "/overrun_sticky"}, int'(m_overrun), 1);
  endtask

  initial begin
    int ldac_low_post, busy_post;
    reset = 1'b1; tick = 1'b0; sel = 0; da = '0; db = '0;

    vecs[0] = '{sel: 0, h: 1, a: 12'hABC, b: 12'h123, fa: 16'h3ABC, fb: 16'hB123};
    vecs[1] = '{sel: 0, h: 1, a: 12'h000, b: 12'hFFF, fa: 16'h3000, fb: 16'hBFFF};
    vecs[2] = '{sel: 0, h: 1, a: 12'h5A5, b: 12'hA5A, fa: 16'h35A5, fb: 16'hBA5A};
    vecs[3] = '{sel: 1, h: 3, a: 12'h800, b: 12'h001, fa: 16'h3800, fb: 16'hB001};
    vecs[4] = '{sel: 2, h: 1, a: 12'h0FF, b: 12'h001, fa: 16'h3FF0, fb: 16'hB010};
    vecs[5] = '{sel: 2, h: 1, a: 12'h080, b: 12'h07F, fa: 16'h3800, fb: 16'hB7F0};

    repeat (3) @(negedge clk0);
    check("rst/sck",     int'(m_sck), 0);
    check("rst/cs_n",    int'(m_cs_n), 1);
    check("rst/sdi",     int'(m_sdi), 0);
    check("rst/busy",    int'(m_busy), 0);
    check("rst/overrun", int'(m_overrun), 0);
`ifdef SPI_DAC_TX_LDAC_EN
    check("rst/ldac_n",  int'(m_ldac_n), 1);
`else
    check("rst/ldac_n",  int'(m_ldac_n), 0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk0);

    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      run_xfer($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].h, 0, vecs[i].fa, vecs[i].fb);
      repeat (3) @(negedge clk0);
    end

    sel = 0;
    run_xfer("ovr_mid", 12'h456, 12'h789, 1, 20, 16'h3456, 16'hB789);
    idle_check("ovr_mid");

    @(negedge clk0) reset = 1'b1;
    @(negedge clk0) reset = 1'b0;
    check("ovr_cleared_by_reset", int'(m_overrun), 0);
    run_xfer("ovr_last", 12'hFED, 12'h0C3, 1, xfer_len(1), 16'h3FED, 16'hB0C3);
    idle_check("ovr_last");

    @(negedge clk0) reset = 1'b1;
    @(negedge clk0) reset = 1'b0;
    @(negedge clk0);
    tick = 1'b1; da = 12'h321; db = 12'h654;
    @(negedge clk0);
    tick = 1'b0;
    repeat (9) @(negedge clk0);
    check("rst_mid/cs_active", int'(m_cs_n), 0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid/cs_n", int'(m_cs_n), 1);
    check("rst_mid/sck",  int'(m_sck), 0);
    check("rst_mid/busy", int'(m_busy), 0);
    repeat (2) @(negedge clk0);
    reset = 1'b0;
    ldac_low_post = 0; busy_post = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk0);
      if (!m_ldac_n) ldac_low_post++;
      if (m_busy) busy_post++;
    end
    check("rst_mid/idle_after", busy_post, 0);
`ifdef SPI_DAC_TX_LDAC_EN
    check("rst_mid/no_ldac", ldac_low_post, 0);
`else
    check("rst_mid/ldac_tied_low", ldac_low_post, 80);
`endif
    run_xfer("rst_mid/clean", 12'hABC, 12'h123, 1, 0, 16'h3ABC, 16'hB123);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
